// File: rtl/clock_divider.sv
// Eight-stage binary clock divider: a free-running 8-bit counter whose bits
// are the /2 .. /256 divided outputs, each taken straight from a flop.
module clock_divider (
    input  logic clk,
    input  logic rst,
    output logic clk_div_2,
    output logic clk_div_4,
    output logic clk_div_8,
    output logic clk_div_16,
    output logic clk_div_32,
    output logic clk_div_64,
    output logic clk_div_128,
    output logic clk_div_256
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    // Next count: modulo-256 increment, wrap 255 -> 0 falls out of the width.
    always_comb begin
        cnt_d = cnt_q + 8'd1;
    end

    // Counter register with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign clk_div_2   = cnt_q[0];
    assign clk_div_4   = cnt_q[1];
    assign clk_div_8   = cnt_q[2];
    assign clk_div_16  = cnt_q[3];
    assign clk_div_32  = cnt_q[4];
    assign clk_div_64  = cnt_q[5];
    assign clk_div_128 = cnt_q[6];
    assign clk_div_256 = cnt_q[7];

endmodule

// File: tb/tb_clock_divider.sv
// Directed bench for clock_divider: reset hold, release, mid-run reset,
// full wrap, period/duty and phase relation of all eight outputs.
module tb_clock_divider;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clk_div_2, clk_div_4, clk_div_8, clk_div_16;
    logic clk_div_32, clk_div_64, clk_div_128, clk_div_256;
    logic [7:0] dout;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] model;

    clock_divider dut (
        .clk         (clk),
        .rst         (rst),
        .clk_div_2   (clk_div_2),
        .clk_div_4   (clk_div_4),
        .clk_div_8   (clk_div_8),
        .clk_div_16  (clk_div_16),
        .clk_div_32  (clk_div_32),
        .clk_div_64  (clk_div_64),
        .clk_div_128 (clk_div_128),
        .clk_div_256 (clk_div_256)
    );

    assign dout = {clk_div_256, clk_div_128, clk_div_64, clk_div_32,
                   clk_div_16, clk_div_8, clk_div_4, clk_div_2};

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%b expected=%b", tag, obs, exp);
            $error("%s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Drive rst for one edge, push the expected count, then pop and compare.
    task automatic step(input logic r, input string tag);
        rst = r;
        model = r ? 8'd0 : model + 8'd1;
        exp_q.push_back(model);
        @(posedge clk);
        #1;
        check(tag, dout, exp_q.pop_front());
    endtask

    initial begin
        logic e2[5];
        logic e4[5];
        logic e8[5];
        int hi_run;
        int hi_max;
        int last_rise[8];
        logic [7:0] prev;
        logic [7:0] cur;

        e2 = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        e4 = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        e8 = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

        // Reset hold
        for (int i = 0; i < 3; i++) begin
            step(1'b1, "reset_hold");
            check("reset_zero", dout, 8'h00);
        end

        // Release and count
        for (int i = 0; i < 5; i++) begin
            step(1'b0, "release_count");
            check("release_bits", {5'd0, dout[2:0]}, {5'd0, e8[i], e4[i], e2[i]});
        end

        // Reset mid-operation, held for 10 more cycles, then release
        step(1'b1, "mid_reset");
        check("mid_reset_zero", dout, 8'h00);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, "mid_reset_hold");
        end
        step(1'b0, "mid_release");
        check("mid_release_first", dout, 8'h01);

        // Full period and wrap
        step(1'b1, "wrap_reset");
        hi_run = 0;
        hi_max = 0;
        for (int i = 1; i <= 256; i++) begin
            step(1'b0, "wrap_count");
            if (dout[7] === 1'b1) begin
                hi_run++;
            end else begin
                hi_run = 0;
            end
            if (hi_run > hi_max) hi_max = hi_run;
            if (i == 255) check("edge255_all_ones", dout, 8'hFF);
            if (i == 256) check("edge256_all_zero", dout, 8'h00);
        end
        check("div256_high_len", hi_max[7:0], 8'd128);

        // Period, duty and phase over 512 cycles
        step(1'b1, "period_reset");
        prev = dout;
        for (int k = 0; k < 8; k++) last_rise[k] = -1;
        for (int i = 1; i <= 512; i++) begin
            step(1'b0, "period_count");
            cur = dout;
            for (int k = 0; k < 8; k++) begin
                if (!prev[k] && cur[k]) begin
                    if (last_rise[k] >= 0)
                        check("period", 8'(i - last_rise[k] - 1), 8'((2 << k) - 1));
                    last_rise[k] = i;
                end
                if (prev[k] && !cur[k] && last_rise[k] >= 0)
                    check("high_time", 8'(i - last_rise[k]), 8'(1 << k));
            end
            for (int k = 0; k < 7; k++) begin
                check("phase", {7'd0, prev[k+1] ^ cur[k+1]}, {7'd0, prev[k] & ~cur[k]});
            end
            prev = cur;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
